// File: rtl/alu_seq.sv
// Handshaked ALU: captures a/b/s on in_valid&&in_ready and holds a 2*WIDTH-bit result plus zero/carry flags.
// Latency: 1 cycle for logic/arith ops, WIDTH+1 cycles for MUL (shift-add, one multiplier bit per cycle).
// Backpressure: DONE holds y/flags until out_ready; in_ready is low while BUSY or DONE, so nothing is queued.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           s,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y,
    output logic                 zero,
    output logic                 carry
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [RW-1:0]    r_y;
    logic             r_zero;
    logic             r_carry;
    logic [RW-1:0]    r_acc;
    logic [RW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_mul_last;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [RW-1:0]    w_a_ext;
    logic [RW-1:0]    w_b_ext;
    logic             w_shl_oor;
    logic [RW-1:0]    w_res;
    logic             w_carry;
    logic [RW-1:0]    w_acc_nxt;

    assign w_accept   = in_valid && (r_state == IDLE);
    assign w_mul_last = (r_state == BUSY) && (r_cnt == CW'(WIDTH - 1));

    assign w_sum     = {1'b0, a} + {1'b0, b};
    assign w_diff    = {1'b0, a} - {1'b0, b};
    assign w_a_ext   = {{WIDTH{1'b0}}, a};
    assign w_b_ext   = {{WIDTH{1'b0}}, b};
    assign w_shl_oor = (32'(b) >= 32'(RW));

    // Single-cycle result; MUL is produced by the iterative datapath instead.
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        case (s)
            OP_ADD: begin
                w_res   = {{(WIDTH-1){1'b0}}, w_sum};
                w_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res   = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
                w_carry = w_diff[WIDTH];
            end
            OP_MUL: w_res = '0;
            OP_AND: w_res = w_a_ext & w_b_ext;
            OP_OR:  w_res = w_a_ext | w_b_ext;
            OP_XOR: w_res = w_a_ext ^ w_b_ext;
            OP_SHL: w_res = w_shl_oor ? '0 : (w_a_ext << b);
            OP_NOT: w_res = {{WIDTH{1'b0}}, ~a};
            default: w_res = '0;
        endcase
    end

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (s == OP_MUL) ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (w_mul_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // y/flags only change on a non-MUL accept or the last multiply iteration, so they hold through DONE and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y      <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            if (s == OP_MUL) begin
                r_acc    <= '0;
                r_mcand  <= w_a_ext;
                r_mplier <= b;
                r_cnt    <= '0;
            end else begin
                r_y     <= w_res;
                r_zero  <= (w_res == '0);
                r_carry <= w_carry;
            end
        end else if (r_state == BUSY) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_mul_last) begin
                r_y     <= w_acc_nxt;
                r_zero  <= (w_acc_nxt == '0);
                r_carry <= 1'b0;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign y         = r_y;
    assign zero      = r_zero;
    assign carry     = r_carry;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a WIDTH=4 and a WIDTH=8 instance driven by directed vectors.
module tb_alu_seq;
    logic        clk;
    logic        rst_n;

    logic        v4, rdy4, ov4, or4, z4, c4;
    logic [3:0]  a4, b4;
    logic [2:0]  s4;
    logic [7:0]  y4;

    logic        v8, rdy8, ov8, or8, z8, c8;
    logic [7:0]  a8, b8;
    logic [2:0]  s8;
    logic [15:0] y8;

    int checks   = 0;
    int failures = 0;

    logic [17:0] sb4[$];
    logic [17:0] sb8[$];

    alu_seq #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4),
        .a(a4), .b(b4), .s(s4), .out_valid(ov4), .out_ready(or4),
        .y(y4), .zero(z4), .carry(c4)
    );

    alu_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8),
        .a(a8), .b(b8), .s(s8), .out_valid(ov8), .out_ready(or8),
        .y(y8), .zero(z8), .carry(c8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Monitors: pop on each completed output handshake. Packed as {y16, zero, carry}.
    always @(negedge clk) begin
        if (rst_n && ov4 && or4) begin
            if (sb4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out4_unexpected actual=%0h required=none", y4);
            end else begin
                chk("out4", {8'h00, y4, z4, c4}, sb4.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov8 && or8) begin
            if (sb8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out8_unexpected actual=%0h required=none", y8);
            end else begin
                chk("out8", {y8, z8, c8}, sb8.pop_front());
            end
        end
    end

    task automatic run_op(input bit w8, input logic [7:0] ta, input logic [7:0] tb,
                          input logic [2:0] ts, input logic [15:0] ey, input logic ez,
                          input logic ec, input int lat, input string nm);
        int n;
        @(posedge clk); #1;
        if (w8) begin
            a8 = ta; b8 = tb; s8 = ts; v8 = 1'b1;
            sb8.push_back({ey, ez, ec});
        end else begin
            a4 = ta[3:0]; b4 = tb[3:0]; s4 = ts; v4 = 1'b1;
            sb4.push_back({ey, ez, ec});
        end
        @(posedge clk); #1;
        v4 = 1'b0;
        v8 = 1'b0;
        chk({nm, "_rdy_low"}, w8 ? rdy8 : rdy4, 1'b0);
        n = 1;
        while (!(w8 ? ov8 : ov4) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_lat"}, n, lat);
    endtask

    task automatic op_rel(input bit w8, input logic [7:0] ta, input logic [7:0] tb,
                          input logic [2:0] ts, input logic [15:0] ey, input logic ez,
                          input logic ec, input int lat, input string nm);
        run_op(w8, ta, tb, ts, ey, ez, ec, lat, nm);
        @(posedge clk); #1;
        chk({nm, "_rdy_back"}, w8 ? rdy8 : rdy4, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        v4 = 1'b0; a4 = '0; b4 = '0; s4 = '0; or4 = 1'b1;
        v8 = 1'b0; a8 = '0; b8 = '0; s8 = '0; or8 = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy4", rdy4, 1'b1);
        chk("rst_ov4", ov4, 1'b0);
        chk("rst_y4", y4, 8'h00);
        chk("rst_flags4", {z4, c4}, 2'b00);
        chk("rst_rdy8", rdy8, 1'b1);
        chk("rst_ov8", ov8, 1'b0);
        rst_n = 1'b1;

        op_rel(0, 8'h9, 8'h3, 3'b000, 16'h000C, 1'b0, 1'b0, 1, "add");
        op_rel(0, 8'h9, 8'hB, 3'b001, 16'h000E, 1'b0, 1'b1, 1, "sub_borrow");
        op_rel(0, 8'h5, 8'h5, 3'b001, 16'h0000, 1'b1, 1'b0, 1, "sub_zero");
        op_rel(0, 8'hD, 8'hB, 3'b010, 16'h008F, 1'b0, 1'b0, 5, "mul4");
        op_rel(1, 8'hFF, 8'hFF, 3'b010, 16'hFE01, 1'b0, 1'b0, 9, "mul8");

        // Backpressure: result held while new operands are offered.
        or4 = 1'b0;
        run_op(0, 8'hE, 8'h7, 3'b110, 16'h0000, 1'b1, 1'b0, 1, "shl_bp");
        for (int i = 0; i < 10; i++) begin
            a4 = 4'b0001; b4 = 4'b0001; s4 = 3'b000; v4 = 1'b1;
            @(posedge clk); #1;
            chk("bp_y", {y4, z4}, {8'h00, 1'b1});
            chk("bp_ov", {ov4, rdy4}, 2'b10);
        end
        v4 = 1'b0;
        or4 = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {ov4, rdy4}, 2'b01);

        op_rel(0, 8'h5, 8'hB, 3'b000, 16'h0010, 1'b0, 1'b1, 1, "sw_add");
        op_rel(0, 8'h5, 8'hB, 3'b001, 16'h000A, 1'b0, 1'b1, 1, "sw_sub");
        op_rel(0, 8'h5, 8'hB, 3'b010, 16'h0037, 1'b0, 1'b0, 5, "sw_mul");
        op_rel(0, 8'h5, 8'hB, 3'b011, 16'h0001, 1'b0, 1'b0, 1, "sw_and");
        op_rel(0, 8'h5, 8'hB, 3'b100, 16'h000F, 1'b0, 1'b0, 1, "sw_or");
        op_rel(0, 8'h5, 8'hB, 3'b101, 16'h000E, 1'b0, 1'b0, 1, "sw_xor");
        op_rel(0, 8'h5, 8'hB, 3'b110, 16'h0000, 1'b1, 1'b0, 1, "sw_shl");
        op_rel(0, 8'h5, 8'hB, 3'b111, 16'h000A, 1'b0, 1'b0, 1, "sw_not");

        // Reset in the middle of a multiply: no result may appear for it.
        @(posedge clk); #1;
        a4 = 4'b1101; b4 = 4'b1011; s4 = 3'b010; v4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy", {rdy4, ov4}, 2'b00);
        rst_n = 1'b0;
        #1;
        chk("abort_ov", ov4, 1'b0);
        chk("abort_y", y4, 8'h00);
        chk("abort_rdy", rdy4, 1'b1);
        chk("abort_flags", {z4, c4}, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;

        op_rel(0, 8'hA, 8'hB, 3'b011, 16'h000A, 1'b0, 1'b0, 1, "post_and");

        repeat (3) @(posedge clk);
        #1;
        chk("sb4_drained", sb4.size(), 0);
        chk("sb8_drained", sb8.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
